// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin CPU/DMA arbiter for a single-port synchronous memory,
//            with a bounded burst length while the other master waits.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int DATA_W    = 9,
    parameter int ADDR_W    = 9,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [1:0]       c_ST_IDLE    = 2'd0;
    localparam logic [1:0]       c_ST_OWN_CPU = 2'd1;
    localparam logic [1:0]       c_ST_OWN_DMA = 2'd2;
    localparam logic [CNT_W-1:0] c_CNT_LAST   = CNT_W'(MAX_BURST - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_beat_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_last;      // 0 = CPU owned last, 1 = DMA owned last
    logic             w_last_nxt;
    logic             r_cpu_rvalid;
    logic             r_dma_rvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_beat_cnt   <= '0;
            r_last       <= 1'b1;
            r_cpu_rvalid <= 1'b0;
            r_dma_rvalid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_beat_cnt   <= w_cnt_nxt;
            r_last       <= w_last_nxt;
            r_cpu_rvalid <= cpu_gnt & ~cpu_we;
            r_dma_rvalid <= dma_gnt & ~dma_we;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_beat_cnt;
        w_last_nxt  = r_last;
        case (r_state)
            c_ST_IDLE: begin
                if (cpu_req && (!dma_req || r_last)) begin
                    w_state_nxt = c_ST_OWN_CPU;
                    w_cnt_nxt   = '0;
                    w_last_nxt  = 1'b0;
                end else if (dma_req) begin
                    w_state_nxt = c_ST_OWN_DMA;
                    w_cnt_nxt   = '0;
                    w_last_nxt  = 1'b1;
                end
            end
            c_ST_OWN_CPU: begin
                if (cpu_req) begin
                    if (r_beat_cnt == c_CNT_LAST) begin
                        w_cnt_nxt = '0;
                        if (dma_req) begin
                            w_state_nxt = c_ST_OWN_DMA;
                            w_last_nxt  = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_beat_cnt + 1'b1;
                    end
                end else if (dma_req) begin
                    w_state_nxt = c_ST_OWN_DMA;
                    w_cnt_nxt   = '0;
                    w_last_nxt  = 1'b1;
                end else begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            c_ST_OWN_DMA: begin
                if (dma_req) begin
                    if (r_beat_cnt == c_CNT_LAST) begin
                        w_cnt_nxt = '0;
                        if (cpu_req) begin
                            w_state_nxt = c_ST_OWN_CPU;
                            w_last_nxt  = 1'b0;
                        end
                    end else begin
                        w_cnt_nxt = r_beat_cnt + 1'b1;
                    end
                end else if (cpu_req) begin
                    w_state_nxt = c_ST_OWN_CPU;
                    w_cnt_nxt   = '0;
                    w_last_nxt  = 1'b0;
                end else begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign cpu_gnt = (r_state == c_ST_OWN_CPU) & cpu_req;
    assign dma_gnt = (r_state == c_ST_OWN_DMA) & dma_req;

    // Memory port follows the owner; a write only happens on a granted beat.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        case (r_state)
            c_ST_OWN_CPU: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_we    = cpu_gnt & cpu_we;
            end
            c_ST_OWN_DMA: begin
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
                mem_we    = dma_gnt & dma_we;
            end
            default: begin
                mem_addr  = '0;
                mem_wdata = '0;
                mem_we    = 1'b0;
            end
        endcase
    end

    assign cpu_rvalid = r_cpu_rvalid;
    assign dma_rvalid = r_dma_rvalid;
    assign cpu_rdata  = mem_rdata;
    assign dma_rdata  = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed self-checking bench for mem_arbiter (MAX_BURST=4 and 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         n_checks = 0;
    int         n_errors = 0;

    // Instance 0: MAX_BURST=4
    logic       c0_req = 0, c0_we = 0, c0_gnt, c0_rvalid;
    logic [8:0] c0_addr = 0, c0_wdata = 0, c0_rdata;
    logic       d0_req = 0, d0_we = 0, d0_gnt, d0_rvalid;
    logic [8:0] d0_addr = 0, d0_wdata = 0, d0_rdata;
    logic [8:0] m0_addr, m0_wdata, m0_rdata;
    logic       m0_we;
    bit   [8:0] m0_mem [512];
    bit         m0_vld [512];

    // Instance 1: MAX_BURST=1
    logic       c1_req = 0, c1_we = 0, c1_gnt, c1_rvalid;
    logic [8:0] c1_addr = 0, c1_wdata = 0, c1_rdata;
    logic       d1_req = 0, d1_we = 0, d1_gnt, d1_rvalid;
    logic [8:0] d1_addr = 0, d1_wdata = 0, d1_rdata;
    logic [8:0] m1_addr, m1_wdata, m1_rdata;
    logic       m1_we;
    bit   [8:0] m1_mem [512];
    bit         m1_vld [512];

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_W(9), .ADDR_W(9), .MAX_BURST(4)) dut0 (
        .clk(clk), .rst(rst),
        .cpu_req(c0_req), .cpu_we(c0_we), .cpu_addr(c0_addr), .cpu_wdata(c0_wdata),
        .cpu_gnt(c0_gnt), .cpu_rvalid(c0_rvalid), .cpu_rdata(c0_rdata),
        .dma_req(d0_req), .dma_we(d0_we), .dma_addr(d0_addr), .dma_wdata(d0_wdata),
        .dma_gnt(d0_gnt), .dma_rvalid(d0_rvalid), .dma_rdata(d0_rdata),
        .mem_addr(m0_addr), .mem_wdata(m0_wdata), .mem_we(m0_we), .mem_rdata(m0_rdata)
    );

    mem_arbiter #(.DATA_W(9), .ADDR_W(9), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst),
        .cpu_req(c1_req), .cpu_we(c1_we), .cpu_addr(c1_addr), .cpu_wdata(c1_wdata),
        .cpu_gnt(c1_gnt), .cpu_rvalid(c1_rvalid), .cpu_rdata(c1_rdata),
        .dma_req(d1_req), .dma_we(d1_we), .dma_addr(d1_addr), .dma_wdata(d1_wdata),
        .dma_gnt(d1_gnt), .dma_rvalid(d1_rvalid), .dma_rdata(d1_rdata),
        .mem_addr(m1_addr), .mem_wdata(m1_wdata), .mem_we(m1_we), .mem_rdata(m1_rdata)
    );

    // Unwritten locations read back as addr ^ 0x0A5.
    function automatic logic [8:0] init_val(input logic [8:0] a);
        return a ^ 9'h0A5;
    endfunction

    always @(posedge clk) begin
        if (m0_we) begin
            m0_mem[m0_addr] <= m0_wdata;
            m0_vld[m0_addr] <= 1'b1;
        end
        m0_rdata <= m0_vld[m0_addr] ? m0_mem[m0_addr] : init_val(m0_addr);
    end

    always @(posedge clk) begin
        if (m1_we) begin
            m1_mem[m1_addr] <= m1_wdata;
            m1_vld[m1_addr] <= 1'b1;
        end
        m1_rdata <= m1_vld[m1_addr] ? m1_mem[m1_addr] : init_val(m1_addr);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        c0_req = 0; d0_req = 0; c1_req = 0; d1_req = 0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; c0_req = 1; d0_req = 1;
        tick();
        at_neg();
        n_checks++;
        if ({c0_gnt, d0_gnt, m0_we, c0_rvalid, d0_rvalid} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: got gnt/gnt/we/rv/rv=%b required 00000",
                     {c0_gnt, d0_gnt, m0_we, c0_rvalid, d0_rvalid});
        end
        c0_req = 0; d0_req = 0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_cpu_read;
        do_reset();
        c0_req = 1; c0_we = 0; c0_addr = 9'h010;
        at_neg();
        n_checks++;
        if (c0_gnt !== 1'b0) begin n_errors++; $display("FAIL cpu_read_early_gnt: got %b required 0", c0_gnt); end
        tick();
        at_neg();
        n_checks++;
        if ({c0_gnt, d0_gnt, m0_we} !== 3'b100) begin
            n_errors++; $display("FAIL cpu_read_gnt: got cgnt/dgnt/we=%b required 100", {c0_gnt, d0_gnt, m0_we});
        end
        n_checks++;
        if (m0_addr !== 9'h010) begin n_errors++; $display("FAIL cpu_read_addr: got %h required 010", m0_addr); end
        tick();
        c0_req = 0;
        at_neg();
        n_checks++;
        if ({c0_rvalid, d0_rvalid, c0_gnt} !== 3'b100) begin
            n_errors++; $display("FAIL cpu_read_rvalid: got crv/drv/cgnt=%b required 100", {c0_rvalid, d0_rvalid, c0_gnt});
        end
        n_checks++;
        if (c0_rdata !== 9'h0B5) begin n_errors++; $display("FAIL cpu_read_data: got %h required 0b5", c0_rdata); end
        tick();
        at_neg();
        n_checks++;
        if (c0_rvalid !== 1'b0) begin n_errors++; $display("FAIL cpu_read_rvalid_drop: got %b required 0", c0_rvalid); end
    endtask

    task automatic test_round_robin;
        logic ec, ed, pc, pd;
        do_reset();
        c0_req = 1; c0_we = 0; c0_addr = 9'h040;
        d0_req = 1; d0_we = 0; d0_addr = 9'h041;
        at_neg();
        n_checks++;
        if ({c0_gnt, d0_gnt} !== 2'b00) begin n_errors++; $display("FAIL rr_idle_gnt: got %b required 00", {c0_gnt, d0_gnt}); end
        pc = 0; pd = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            at_neg();
            ec = (k <= 4) || (k >= 9);
            ed = !ec;
            n_checks++;
            if ({c0_gnt, d0_gnt} !== {ec, ed}) begin
                n_errors++; $display("FAIL rr_gnt[%0d]: got %b required %b", k, {c0_gnt, d0_gnt}, {ec, ed});
            end
            n_checks++;
            if ({c0_rvalid, d0_rvalid} !== {pc, pd}) begin
                n_errors++; $display("FAIL rr_rvalid[%0d]: got %b required %b", k, {c0_rvalid, d0_rvalid}, {pc, pd});
            end
            if (pc) begin
                n_checks++;
                if (c0_rdata !== 9'h0E5) begin n_errors++; $display("FAIL rr_cpu_data[%0d]: got %h required 0e5", k, c0_rdata); end
            end
            if (pd) begin
                n_checks++;
                if (d0_rdata !== 9'h0E4) begin n_errors++; $display("FAIL rr_dma_data[%0d]: got %h required 0e4", k, d0_rdata); end
            end
            pc = ec; pd = ed;
        end
        c0_req = 0; d0_req = 0;
        tick();
    endtask

    task automatic test_dma_burst;
        logic [8:0] ea, ew;
        do_reset();
        d0_req = 1; d0_we = 1; d0_addr = 9'h100; d0_wdata = 9'h050;
        tick();
        for (int i = 0; i < 10; i++) begin
            at_neg();
            ea = 9'h100 + 9'(i);
            ew = 9'h050 + 9'(i);
            n_checks++;
            if ({d0_gnt, m0_we, c0_gnt, d0_rvalid} !== 4'b1100) begin
                n_errors++; $display("FAIL dma_wr_ctl[%0d]: got dgnt/we/cgnt/drv=%b required 1100", i, {d0_gnt, m0_we, c0_gnt, d0_rvalid});
            end
            n_checks++;
            if ({m0_addr, m0_wdata} !== {ea, ew}) begin
                n_errors++; $display("FAIL dma_wr_bus[%0d]: got addr %h data %h required %h %h", i, m0_addr, m0_wdata, ea, ew);
            end
            tick();
            if (i < 9) begin
                d0_addr = ea + 9'd1; d0_wdata = ew + 9'd1;
            end else begin
                d0_req = 0;
            end
        end
        at_neg();
        n_checks++;
        if ({d0_gnt, d0_rvalid, m0_we} !== 3'b000) begin
            n_errors++; $display("FAIL dma_wr_end: got dgnt/drv/we=%b required 000", {d0_gnt, d0_rvalid, m0_we});
        end
        d0_we = 0;
        tick();
        c0_req = 1; c0_we = 0; c0_addr = 9'h105;
        tick();
        tick();
        c0_req = 0;
        at_neg();
        n_checks++;
        if ({c0_rvalid, c0_rdata} !== {1'b1, 9'h055}) begin
            n_errors++; $display("FAIL dma_wr_readback: got rv %b data %h required 1 055", c0_rvalid, c0_rdata);
        end
        tick();
    endtask

    task automatic test_release_handover;
        do_reset();
        c0_req = 1; c0_we = 0; c0_addr = 9'h010;
        tick();
        d0_req = 1; d0_we = 0; d0_addr = 9'h030;
        for (int b = 1; b <= 2; b++) begin
            at_neg();
            n_checks++;
            if ({c0_gnt, d0_gnt} !== 2'b10) begin
                n_errors++; $display("FAIL rel_cpu_beat[%0d]: got %b required 10", b, {c0_gnt, d0_gnt});
            end
            tick();
        end
        c0_req = 0;
        at_neg();
        n_checks++;
        if ({c0_gnt, d0_gnt, c0_rvalid} !== 3'b001) begin
            n_errors++; $display("FAIL rel_release_cycle: got cgnt/dgnt/crv=%b required 001", {c0_gnt, d0_gnt, c0_rvalid});
        end
        tick();
        at_neg();
        n_checks++;
        if ({c0_gnt, d0_gnt} !== 2'b01) begin
            n_errors++; $display("FAIL rel_dma_gnt: got %b required 01", {c0_gnt, d0_gnt});
        end
        n_checks++;
        if ({dut0.r_state, dut0.r_last} !== 3'b101) begin
            n_errors++; $display("FAIL rel_state_last: got %b required 101", {dut0.r_state, dut0.r_last});
        end
        d0_req = 0;
        tick();
    endtask

    task automatic test_reset_mid;
        do_reset();
        c0_req = 1; c0_we = 0; c0_addr = 9'h010;
        tick();
        rst = 1'b1;
        at_neg();
        n_checks++;
        if (c0_gnt !== 1'b1) begin n_errors++; $display("FAIL rstmid_gnt: got %b required 1", c0_gnt); end
        tick();
        rst = 1'b0;
        d0_req = 1; d0_we = 0; d0_addr = 9'h030;
        at_neg();
        n_checks++;
        if ({c0_rvalid, c0_gnt, d0_gnt, m0_we} !== 4'b0000) begin
            n_errors++; $display("FAIL rstmid_suppress: got crv/cgnt/dgnt/we=%b required 0000", {c0_rvalid, c0_gnt, d0_gnt, m0_we});
        end
        tick();
        at_neg();
        n_checks++;
        if ({c0_gnt, d0_gnt} !== 2'b10) begin
            n_errors++; $display("FAIL rstmid_first_tie: got %b required 10", {c0_gnt, d0_gnt});
        end
        c0_req = 0; d0_req = 0;
        tick();
    endtask

    task automatic test_alternate;
        logic ec, ed, pc, pd;
        do_reset();
        c1_req = 1; c1_we = 0; c1_addr = 9'h020;
        d1_req = 1; d1_we = 0; d1_addr = 9'h030;
        at_neg();
        n_checks++;
        if ({c1_gnt, d1_gnt} !== 2'b00) begin n_errors++; $display("FAIL alt_idle_gnt: got %b required 00", {c1_gnt, d1_gnt}); end
        pc = 0; pd = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            at_neg();
            ec = (k % 2) == 1;
            ed = !ec;
            n_checks++;
            if ({c1_gnt, d1_gnt} !== {ec, ed}) begin
                n_errors++; $display("FAIL alt_gnt[%0d]: got %b required %b", k, {c1_gnt, d1_gnt}, {ec, ed});
            end
            n_checks++;
            if ({c1_rvalid, d1_rvalid} !== {pc, pd}) begin
                n_errors++; $display("FAIL alt_rvalid[%0d]: got %b required %b", k, {c1_rvalid, d1_rvalid}, {pc, pd});
            end
            if (pc) begin
                n_checks++;
                if (c1_rdata !== 9'h085) begin n_errors++; $display("FAIL alt_cpu_data[%0d]: got %h required 085", k, c1_rdata); end
            end
            if (pd) begin
                n_checks++;
                if (d1_rdata !== 9'h095) begin n_errors++; $display("FAIL alt_dma_data[%0d]: got %h required 095", k, d1_rdata); end
            end
            pc = ec; pd = ed;
        end
        c1_req = 0; d1_req = 0;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_cpu_read();
        test_round_robin();
        test_dma_burst();
        test_release_handover();
        test_reset_mid();
        test_alternate();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
